ssg_disp_arb: RTL and testbench

SSG_DISP_ARB -- requirements
Module: ssg_disp_arb

---
 rtl/ssg_pkg.sv | 48 ++++
 rtl/ssg_dwell_timer.sv | 26 ++
 rtl/ssg_disp_arb.sv | 111 +++++++++++
 tb/tb_ssg_disp_arb.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ssg_pkg.sv
// Shared types and constants for the display arbiter: state encoding, CFG field
// positions and the idle display image.
package ssg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_OWN0 = 2'b01,
    ST_OWN1 = 2'b10
  } state_t;

  localparam int unsigned CFG_USE_SEG   = 9;
  localparam int unsigned CFG_AUTOBLANK = 8;
  localparam int unsigned CFG_BLINK_LSB = 4;
  localparam int unsigned CFG_BLANK_LSB = 0;

  typedef struct packed {
    logic [15:0] din;
    logic [31:0] seg;
    logic [3:0]  blank;
    logic [3:0]  blink;
    logic        use_seg;
    logic        autoblank;
  } disp_t;

  // Idle image: every anode blanked, segments all-ones (off).
  localparam disp_t IDLE_DISP = '{
    din:       '0,
    seg:       '1,
    blank:     '1,
    blink:     '0,
    use_seg:   1'b0,
    autoblank: 1'b0
  };

  function automatic disp_t client_disp(input logic [15:0] din,
                                        input logic [31:0] seg,
                                        input logic [9:0]  cfg);
    disp_t d;
    d.din       = din;
    d.seg       = seg;
    d.blank     = cfg[CFG_BLANK_LSB +: 4];
    d.blink     = cfg[CFG_BLINK_LSB +: 4];
    d.use_seg   = cfg[CFG_USE_SEG];
    d.autoblank = cfg[CFG_AUTOBLANK];
    return d;
  endfunction

endpackage

// File: rtl/ssg_dwell_timer.sv
// 32-bit saturating ownership timer; expired holds once DWELL_CYCLES-1 is reached.
module ssg_dwell_timer #(
  parameter int unsigned DWELL_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [31:0] LAST = (DWELL_CYCLES == 0) ? 32'd0 : 32'(DWELL_CYCLES - 1);

  logic [31:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + 32'd1;
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/ssg_disp_arb.sv
// Two-client seven-segment display arbiter with dwell-based round-robin.
// Define SSG_ARB_PREEMPT_EN to make client 1 a preempting alert client.
import ssg_pkg::*;

module ssg_disp_arb #(
  parameter int unsigned CLK_FREQUENCY_HZ = 50000000,
  parameter int unsigned DWELL_MS         = 1000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [1:0]  REQ,
  input  logic [15:0] C0_DIN,
  input  logic [15:0] C1_DIN,
  input  logic [31:0] C0_SEG,
  input  logic [31:0] C1_SEG,
  input  logic [9:0]  C0_CFG,
  input  logic [9:0]  C1_CFG,
  output logic [1:0]  GNT,
  output logic [15:0] DIN,
  output logic [31:0] SEG_DATA,
  output logic [3:0]  BLANK,
  output logic [3:0]  BLINK,
  output logic        USE_SEGMENT_DATA,
  output logic        AUTOBLANK
);

  localparam int unsigned DWELL_CYCLES = (CLK_FREQUENCY_HZ / 1000) * DWELL_MS;

  state_t state;
  state_t nxt;
  logic   last;
  logic   expired;
  disp_t  disp;

  ssg_dwell_timer #(.DWELL_CYCLES(DWELL_CYCLES)) u_timer (
    .clk     (CLK),
    .reset   (RESET),
    .clear   (nxt != state),
    .enable  (state != ST_IDLE),
    .expired (expired)
  );

  always_comb begin
    nxt = state;
    unique case (state)
      ST_IDLE: begin
        unique case (REQ)
          2'b01:   nxt = ST_OWN0;
          2'b10:   nxt = ST_OWN1;
`ifdef SSG_ARB_PREEMPT_EN
          2'b11:   nxt = ST_OWN1;
`else
          2'b11:   nxt = last ? ST_OWN0 : ST_OWN1;
`endif
          default: nxt = ST_IDLE;
        endcase
      end
      ST_OWN0: begin
        if (!REQ[0])
          nxt = REQ[1] ? ST_OWN1 : ST_IDLE;
`ifdef SSG_ARB_PREEMPT_EN
        else if (REQ[1])
          nxt = ST_OWN1;
`else
        else if (REQ[1] && expired)
          nxt = ST_OWN1;
`endif
      end
      ST_OWN1: begin
        if (!REQ[1])
          nxt = REQ[0] ? ST_OWN0 : ST_IDLE;
`ifndef SSG_ARB_PREEMPT_EN
        else if (REQ[0] && expired)
          nxt = ST_OWN0;
`endif
      end
      default: nxt = ST_IDLE;
    endcase
  end

  // Outputs are loaded from the next state so a grant and its data land on the same edge.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= ST_IDLE;
      last  <= 1'b1;
      disp  <= IDLE_DISP;
    end else begin
      state <= nxt;
      unique case (nxt)
        ST_OWN0: begin
          last <= 1'b0;
          disp <= client_disp(C0_DIN, C0_SEG, C0_CFG);
        end
        ST_OWN1: begin
          last <= 1'b1;
          disp <= client_disp(C1_DIN, C1_SEG, C1_CFG);
        end
        default: disp <= IDLE_DISP;
      endcase
    end
  end

  assign GNT              = state;
  assign DIN              = disp.din;
  assign SEG_DATA         = disp.seg;
  assign BLANK            = disp.blank;
  assign BLINK            = disp.blink;
  assign USE_SEGMENT_DATA = disp.use_seg;
  assign AUTOBLANK        = disp.autoblank;

endmodule

// File: tb/tb_ssg_disp_arb.sv
// Directed bench for ssg_disp_arb at 1 MHz / 1 ms dwell (1000 cycles).
module tb_ssg_disp_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [15:0] c0_din, c1_din;
  logic [31:0] c0_seg, c1_seg;
  logic [9:0]  c0_cfg, c1_cfg;
  logic [1:0]  gnt;
  logic [15:0] din;
  logic [31:0] seg_data;
  logic [3:0]  blank, blink;
  logic        use_seg, autoblank;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ssg_disp_arb #(.CLK_FREQUENCY_HZ(1000000), .DWELL_MS(1)) dut (
    .CLK(clk), .RESET(rst), .REQ(req),
    .C0_DIN(c0_din), .C1_DIN(c1_din),
    .C0_SEG(c0_seg), .C1_SEG(c1_seg),
    .C0_CFG(c0_cfg), .C1_CFG(c1_cfg),
    .GNT(gnt), .DIN(din), .SEG_DATA(seg_data),
    .BLANK(blank), .BLINK(blink),
    .USE_SEGMENT_DATA(use_seg), .AUTOBLANK(autoblank)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  req;
    logic [15:0] c0din;
    logic [9:0]  c0cfg;
    logic [1:0]  gnt;
    logic [15:0] din;
    logic [31:0] seg;
    logic [3:0]  blank;
    logic [3:0]  blink;
    logic        us;
    logic        ab;
  } vec_t;

  localparam int NV = 13;
  vec_t tbl [NV];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, " gnt"},   32'(gnt), 32'd0);
    chk({nm, " din"},   32'(din), 32'd0);
    chk({nm, " seg"},   seg_data, 32'hFFFF_FFFF);
    chk({nm, " blank"}, 32'(blank), 32'hF);
    chk({nm, " blink"}, 32'(blink), 32'd0);
    chk({nm, " us"},    32'(use_seg), 32'd0);
    chk({nm, " ab"},    32'(autoblank), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 2'b00;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int n;
    logic ok;
    rst    = 1'b1;
    req    = 2'b00;
    c0_din = 16'h1234;
    c0_seg = 32'hA5A5_0001;
    c0_cfg = 10'h000;
    c1_din = 16'hBEEF;
    c1_seg = 32'h0F0F_1234;
    c1_cfg = 10'h2A5;

    //            rst  req    c0din     c0cfg     gnt   din       seg             blank blink us    ab
    tbl[0]  = '{1'b1, 2'b00, 16'h1234, 10'h000, 2'd0, 16'h0000, 32'hFFFF_FFFF, 4'hF, 4'h0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 2'b01, 16'h1234, 10'h000, 2'd0, 16'h0000, 32'hFFFF_FFFF, 4'hF, 4'h0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 2'b01, 16'h1234, 10'h000, 2'd1, 16'h1234, 32'hA5A5_0001, 4'h0, 4'h0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 2'b01, 16'h5678, 10'h3FF, 2'd1, 16'h5678, 32'hA5A5_0001, 4'hF, 4'hF, 1'b1, 1'b1};
    tbl[4]  = '{1'b0, 2'b01, 16'h5678, 10'h1C3, 2'd1, 16'h5678, 32'hA5A5_0001, 4'h3, 4'hC, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 2'b00, 16'h5678, 10'h1C3, 2'd0, 16'h0000, 32'hFFFF_FFFF, 4'hF, 4'h0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 2'b10, 16'h5678, 10'h1C3, 2'd2, 16'hBEEF, 32'h0F0F_1234, 4'h5, 4'hA, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 2'b10, 16'h9ABC, 10'h000, 2'd2, 16'hBEEF, 32'h0F0F_1234, 4'h5, 4'hA, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 2'b01, 16'h9ABC, 10'h000, 2'd1, 16'h9ABC, 32'hA5A5_0001, 4'h0, 4'h0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 2'b00, 16'h9ABC, 10'h000, 2'd0, 16'h0000, 32'hFFFF_FFFF, 4'hF, 4'h0, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 2'b10, 16'h9ABC, 10'h000, 2'd0, 16'h0000, 32'hFFFF_FFFF, 4'hF, 4'h0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 2'b10, 16'h9ABC, 10'h000, 2'd2, 16'hBEEF, 32'h0F0F_1234, 4'h5, 4'hA, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 2'b10, 16'h9ABC, 10'h000, 2'd0, 16'h0000, 32'hFFFF_FFFF, 4'hF, 4'h0, 1'b0, 1'b0};

    for (int i = 0; i < NV; i++) begin
      rst    = tbl[i].rst;
      req    = tbl[i].req;
      c0_din = tbl[i].c0din;
      c0_cfg = tbl[i].c0cfg;
      step();
      chk($sformatf("vec%0d gnt", i),   32'(gnt),       32'(tbl[i].gnt));
      chk($sformatf("vec%0d din", i),   32'(din),       32'(tbl[i].din));
      chk($sformatf("vec%0d seg", i),   seg_data,       tbl[i].seg);
      chk($sformatf("vec%0d blank", i), 32'(blank),     32'(tbl[i].blank));
      chk($sformatf("vec%0d blink", i), 32'(blink),     32'(tbl[i].blink));
      chk($sformatf("vec%0d us", i),    32'(use_seg),   32'(tbl[i].us));
      chk($sformatf("vec%0d ab", i),    32'(autoblank), 32'(tbl[i].ab));
    end

    // Simultaneous request asserted together with reset; reset wins that edge.
    c0_din = 16'h1234;
    rst = 1'b1;
    req = 2'b11;
    step();
    chk_idle("rst_req11");
    rst = 1'b0;
    step();
`ifdef SSG_ARB_PREEMPT_EN
    chk("both_first gnt", 32'(gnt), 32'd2);
    chk("both_first din", 32'(din), 32'hBEEF);
    ok = 1'b1;
    for (int k = 0; k < 1200; k++) begin
      step();
      if (gnt !== 2'd2) ok = 1'b0;
    end
    chk("own1_hold_no_expiry", 32'(ok), 32'd1);
    req = 2'b01;
    step();
    chk("own1_release gnt", 32'(gnt), 32'd1);

    // Preemption at cycle 5 of OWN0.
    do_reset();
    req = 2'b01;
    step();
    chk("pre_own0 gnt", 32'(gnt), 32'd1);
    for (int k = 0; k < 4; k++) step();
    req = 2'b11;
    step();
    chk("preempt gnt", 32'(gnt), 32'd2);
    chk("preempt din", 32'(din), 32'hBEEF);
    ok = 1'b1;
    for (int k = 0; k < 1200; k++) begin
      step();
      if (gnt !== 2'd2) ok = 1'b0;
    end
    chk("preempt_hold", 32'(ok), 32'd1);
    req = 2'b01;
    step();
    chk("preempt_release gnt", 32'(gnt), 32'd1);
`else
    chk("both_first gnt", 32'(gnt), 32'd1);
    chk("both_first din", 32'(din), 32'h1234);
    n = 0;
    for (int k = 1; k <= 1100; k++) begin
      step();
      if (gnt !== 2'd1) begin
        n = k;
        break;
      end
    end
    chk("rr_switch_cycle", 32'(n), 32'd1000);
    chk("rr_switch gnt", 32'(gnt), 32'd2);
    n = 0;
    for (int k = 1; k <= 1100; k++) begin
      step();
      if (gnt !== 2'd2) begin
        n = k;
        break;
      end
    end
    chk("rr_back_cycle", 32'(n), 32'd1000);
    chk("rr_back gnt", 32'(gnt), 32'd1);
`endif

    // Drop the only request at cycle 10 of ownership.
    do_reset();
    req = 2'b01;
    step();
    for (int k = 0; k < 9; k++) step();
    req = 2'b00;
    step();
    chk_idle("drop10");

    // Saturated dwell with no competitor holds; competitor then switches at once.
    req = 2'b01;
    step();
    ok = 1'b1;
    for (int k = 0; k < 1100; k++) begin
      step();
      if (gnt !== 2'd1) ok = 1'b0;
    end
    chk("sat_hold", 32'(ok), 32'd1);
    req = 2'b11;
    step();
    chk("sat_switch gnt", 32'(gnt), 32'd2);
    chk("sat_switch seg", seg_data, 32'h0F0F_1234);

    // Last-owner priority on simultaneous requests from IDLE.
    req = 2'b00;
    step();
    req = 2'b11;
    step();
`ifdef SSG_ARB_PREEMPT_EN
    chk("last1_both gnt", 32'(gnt), 32'd2);
`else
    chk("last1_both gnt", 32'(gnt), 32'd1);
`endif
    req = 2'b00;
    step();
    req = 2'b11;
    step();
    chk("last0_both gnt", 32'(gnt), 32'd2);

    // Reset at cycle 500 of OWN1.
    do_reset();
    req = 2'b10;
    step();
    chk("own1_grant gnt", 32'(gnt), 32'd2);
    for (int k = 0; k < 499; k++) step();
    rst = 1'b1;
    step();
    chk_idle("rst_own1");
    rst = 1'b0;
    req = 2'b11;
    step();
`ifdef SSG_ARB_PREEMPT_EN
    chk("post_rst gnt", 32'(gnt), 32'd2);
`else
    chk("post_rst gnt", 32'(gnt), 32'd1);
    chk("post_rst din", 32'(din), 32'h1234);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
